// File: rtl/mem_access_stage.sv
// MEM-stage data-memory unit: multi-cycle byte/half/word loads and stores against a
// word-organised memory, stalling upstream and feeding the MEM/WB register.
module mem_access_stage #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic [1:0]  in_Size,
    input  logic        in_Unsigned,
    input  logic [31:0] in_ALU_result,
    input  logic [31:0] in_Write_data,
    input  logic [4:0]  in_Reg_Write_addr,
    input  logic        in_MemToReg,
    input  logic        in_RegWrite,
    output logic        out_stall,
    output logic [31:0] out_DM_Read_data,
    output logic [31:0] out_ALU_result,
    output logic [4:0]  out_Reg_Write_addr,
    output logic        out_MemToReg,
    output logic        out_RegWrite,
    output logic        out_misaligned
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ld_q, ld_d;

    logic [31:0] mem_q [0:(1 << ADDR_WIDTH) - 1];

    logic                  mem_op;
    logic                  violation;
    logic                  misaligned;
    logic                  commit;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]            boff;
    logic [31:0]           cur_word;

    function automatic logic [31:0] load_extend(input logic [31:0] f_word,
                                                input logic [1:0]  f_size,
                                                input logic [1:0]  f_off,
                                                input logic        f_uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (f_off)
            2'd0:    b = f_word[7:0];
            2'd1:    b = f_word[15:8];
            2'd2:    b = f_word[23:16];
            default: b = f_word[31:24];
        endcase
        h = f_off[1] ? f_word[31:16] : f_word[15:0];
        case (f_size)
            2'b00:   return f_uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return f_uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return f_word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] f_old,
                                                input logic [31:0] f_wdata,
                                                input logic [1:0]  f_size,
                                                input logic [1:0]  f_off);
        logic [31:0] r;
        r = f_old;
        case (f_size)
            2'b00: begin
                case (f_off)
                    2'd0:    r[7:0]   = f_wdata[7:0];
                    2'd1:    r[15:8]  = f_wdata[7:0];
                    2'd2:    r[23:16] = f_wdata[7:0];
                    default: r[31:24] = f_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (f_off[1]) r[31:16] = f_wdata[15:0];
                else          r[15:0]  = f_wdata[15:0];
            end
            default: r = f_wdata;
        endcase
        return r;
    endfunction

    assign widx     = in_ALU_result[ADDR_WIDTH+1:2];
    assign boff     = in_ALU_result[1:0];
    assign cur_word = mem_q[widx];

    assign mem_op     = in_valid & (in_MemRead | in_MemWrite);
    assign violation  = (in_Size == 2'b01) ? boff[0] :
                        (in_Size == 2'b00) ? 1'b0 : (boff != 2'b00);
    assign misaligned = mem_op & violation;

    // Reset on the commit edge cancels the pending store.
    assign commit = (state_q == BUSY) && (cnt_q == 4'd0) && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ld_q    <= ld_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (commit && in_MemWrite) begin
            mem_q[widx] <= store_merge(cur_word, in_Write_data, in_Size, boff);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ld_d    = ld_q;
        case (state_q)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    ld_d    = in_MemRead;
                    if (in_MemRead) begin
                        rdata_d = load_extend(cur_word, in_Size, boff, in_Unsigned);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:    stall = mem_op & !misaligned;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
        stall = stall & !RST;

        out_stall          = stall;
        out_ALU_result     = in_ALU_result;
        out_Reg_Write_addr = in_Reg_Write_addr;
        out_RegWrite       = !RST & in_valid & in_RegWrite & !stall & !misaligned;
        out_MemToReg       = !RST & in_valid & in_MemToReg & !stall & !misaligned;
        out_misaligned     = !RST & misaligned;
        out_DM_Read_data   = (!RST && state_q == DONE && ld_q) ? rdata_q : 32'd0;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table through a scoreboard, plus hand-written
// reset-mid-store and LATENCY=3 sequences.
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        v2, v3;
    logic        rd, wr, uns, mtr, rw;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [4:0]  rda;

    logic        stall2, mtr2, rw2, mis2;
    logic [31:0] data2, alu2;
    logic [4:0]  rda2;
    logic        stall3, mtr3, rw3, mis3;
    logic [31:0] data3, alu3;
    logic [4:0]  rda3;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    mem_access_stage #(.ADDR_WIDTH(10), .LATENCY(2)) dut2 (
        .CLK(CLK), .RST(RST), .in_valid(v2), .in_MemRead(rd), .in_MemWrite(wr),
        .in_Size(size), .in_Unsigned(uns), .in_ALU_result(addr), .in_Write_data(wdata),
        .in_Reg_Write_addr(rda), .in_MemToReg(mtr), .in_RegWrite(rw),
        .out_stall(stall2), .out_DM_Read_data(data2), .out_ALU_result(alu2),
        .out_Reg_Write_addr(rda2), .out_MemToReg(mtr2), .out_RegWrite(rw2),
        .out_misaligned(mis2));

    mem_access_stage #(.ADDR_WIDTH(10), .LATENCY(3)) dut3 (
        .CLK(CLK), .RST(RST), .in_valid(v3), .in_MemRead(rd), .in_MemWrite(wr),
        .in_Size(size), .in_Unsigned(uns), .in_ALU_result(addr), .in_Write_data(wdata),
        .in_Reg_Write_addr(rda), .in_MemToReg(mtr), .in_RegWrite(rw),
        .out_stall(stall3), .out_DM_Read_data(data3), .out_ALU_result(alu3),
        .out_Reg_Write_addr(rda3), .out_MemToReg(mtr3), .out_RegWrite(rw3),
        .out_misaligned(mis3));

    typedef struct {
        logic        valid, rd, wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, wdata;
        logic [4:0]  rda;
        logic        mtr, rw;
        logic [31:0] e_data;
        logic        e_rw, e_mtr, e_mis;
        int          e_stalls;
    } vec_t;

    typedef struct {
        logic [31:0] data, alu;
        logic [4:0]  rda;
        logic        rw, mtr, mis;
        int          stalls;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vl, input logic r, input logic w,
                                input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [4:0] d, input logic m, input logic g,
                                input logic [31:0] ed, input logic erw, input logic emtr,
                                input logic emis, input int est);
        vec_t v;
        v.valid = vl; v.rd = r; v.wr = w; v.size = sz; v.uns = u;
        v.addr = a; v.wdata = wd; v.rda = d; v.mtr = m; v.rw = g;
        v.e_data = ed; v.e_rw = erw; v.e_mtr = emtr; v.e_mis = emis; v.e_stalls = est;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        v2 = v.valid; rd = v.rd; wr = v.wr; size = v.size; uns = v.uns;
        addr = v.addr; wdata = v.wdata; rda = v.rda; mtr = v.mtr; rw = v.rw;
    endtask

    task automatic run_op(input vec_t v);
        exp_t e;
        int   n;
        @(posedge CLK); #1;
        drive(v);
        e.data = v.e_data; e.alu = v.addr; e.rda = v.rda;
        e.rw = v.e_rw; e.mtr = v.e_mtr; e.mis = v.e_mis; e.stalls = v.e_stalls;
        sb.push_back(e);
        n = 0;
        @(negedge CLK);
        while (stall2 && n < 40) begin
            chk("rw_low_during_stall", 32'(rw2), 32'd0);
            n++;
            @(negedge CLK);
        end
        e = sb.pop_front();
        chk("stall_cycles", 32'(n), 32'(e.stalls));
        chk("read_data", data2, e.data);
        chk("reg_write", 32'(rw2), 32'(e.rw));
        chk("mem_to_reg", 32'(mtr2), 32'(e.mtr));
        chk("misaligned", 32'(mis2), 32'(e.mis));
        chk("alu_pass", alu2, e.alu);
        chk("rd_pass", 32'(rda2), 32'(e.rda));
    endtask

    task automatic count_stall3(output int n);
        n = 0;
        @(negedge CLK);
        while (stall3 && n < 40) begin
            chk("l3_rw_low_during_stall", 32'(rw3), 32'd0);
            n++;
            @(negedge CLK);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // valid rd wr size uns addr wdata rd# mtr rw | data rw mtr mis stalls
        tbl.push_back(mk(1,0,1,2'b10,0,32'h10,32'hDEADBEEF,0,0,0, 32'h0,0,0,0,3));
        tbl.push_back(mk(1,1,0,2'b10,0,32'h10,32'h0,3,1,1, 32'hDEADBEEF,1,1,0,3));
        tbl.push_back(mk(1,0,1,2'b10,0,32'h20,32'h12345680,0,0,0, 32'h0,0,0,0,3));
        tbl.push_back(mk(1,1,0,2'b00,0,32'h20,32'h0,4,1,1, 32'hFFFFFF80,1,1,0,3));
        tbl.push_back(mk(1,1,0,2'b00,1,32'h20,32'h0,5,1,1, 32'h00000080,1,1,0,3));
        tbl.push_back(mk(1,1,0,2'b01,0,32'h22,32'h0,6,1,1, 32'h00001234,1,1,0,3));
        tbl.push_back(mk(1,1,0,2'b00,0,32'h23,32'h0,7,1,1, 32'h00000012,1,1,0,3));
        tbl.push_back(mk(1,1,0,2'b00,0,32'h21,32'h0,8,1,1, 32'h00000056,1,1,0,3));
        tbl.push_back(mk(1,0,1,2'b10,0,32'h20,32'h11111111,0,0,0, 32'h0,0,0,0,3));
        tbl.push_back(mk(1,0,1,2'b01,0,32'h22,32'h5555ABCD,0,0,0, 32'h0,0,0,0,3));
        tbl.push_back(mk(1,1,0,2'b10,0,32'h20,32'h0,9,1,1, 32'hABCD1111,1,1,0,3));
        tbl.push_back(mk(1,1,0,2'b01,0,32'h22,32'h0,10,1,1, 32'hFFFFABCD,1,1,0,3));
        tbl.push_back(mk(1,1,0,2'b01,1,32'h22,32'h0,11,1,1, 32'h0000ABCD,1,1,0,3));
        tbl.push_back(mk(1,0,1,2'b00,0,32'h21,32'hFFFFFF7E,0,0,0, 32'h0,0,0,0,3));
        tbl.push_back(mk(1,1,0,2'b10,0,32'h20,32'h0,12,1,1, 32'hABCD7E11,1,1,0,3));
        tbl.push_back(mk(1,0,1,2'b10,0,32'h04,32'h01020304,0,0,0, 32'h0,0,0,0,3));
        tbl.push_back(mk(1,1,0,2'b10,0,32'h06,32'h0,13,1,1, 32'h0,0,0,1,0));
        tbl.push_back(mk(1,0,1,2'b10,0,32'h06,32'hFFFFFFFF,0,0,0, 32'h0,0,0,1,0));
        tbl.push_back(mk(1,0,1,2'b01,0,32'h21,32'hFFFFFFFF,0,0,0, 32'h0,0,0,1,0));
        tbl.push_back(mk(1,1,0,2'b01,0,32'h23,32'h0,14,1,1, 32'h0,0,0,1,0));
        tbl.push_back(mk(1,1,0,2'b10,0,32'h04,32'h0,15,1,1, 32'h01020304,1,1,0,3));
        tbl.push_back(mk(1,1,0,2'b10,0,32'h20,32'h0,16,1,1, 32'hABCD7E11,1,1,0,3));
        tbl.push_back(mk(1,0,0,2'b10,0,32'h42,32'h0,5,0,1, 32'h0,1,0,0,0));
        tbl.push_back(mk(0,1,0,2'b10,0,32'h12,32'h0,17,1,1, 32'h0,0,0,0,0));
        tbl.push_back(mk(1,1,0,2'b11,0,32'h10,32'h0,18,1,1, 32'hDEADBEEF,1,1,0,3));
        tbl.push_back(mk(1,1,0,2'b10,0,32'h1010,32'h0,19,1,1, 32'hDEADBEEF,1,1,0,3));
        tbl.push_back(mk(1,0,1,2'b10,0,32'h30,32'h0,0,0,0, 32'h0,0,0,0,3));

        // Reset asserted with a misaligned load presented: every control must stay low.
        RST = 1'b1; v3 = 1'b0;
        drive(mk(1,1,0,2'b10,0,32'h02,32'h0,1,1,1, 32'h0,0,0,0,0));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_stall", 32'(stall2), 32'd0);
        chk("rst_rw", 32'(rw2), 32'd0);
        chk("rst_mtr", 32'(mtr2), 32'd0);
        chk("rst_mis", 32'(mis2), 32'd0);
        chk("rst_data", data2, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0; v2 = 1'b0;

        foreach (tbl[i]) run_op(tbl[i]);

        // Store cancelled by reset on its commit cycle.
        @(posedge CLK); #1;
        drive(mk(1,0,1,2'b10,0,32'h30,32'hCAFEF00D,0,0,0, 32'h0,0,0,0,0));
        @(negedge CLK);
        chk("sw30_stall_idle", 32'(stall2), 32'd1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("sw30_stall_busy1", 32'(stall2), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1; rw = 1'b1; mtr = 1'b1; addr = 32'h32;
        @(negedge CLK);
        chk("midrst_stall", 32'(stall2), 32'd0);
        chk("midrst_rw", 32'(rw2), 32'd0);
        chk("midrst_mtr", 32'(mtr2), 32'd0);
        chk("midrst_mis", 32'(mis2), 32'd0);
        chk("midrst_data", data2, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0; v2 = 1'b0;
        run_op(mk(1,1,0,2'b10,0,32'h30,32'h0,20,1,1, 32'h0,1,1,0,3));

        // LATENCY=3 instance: store then load, four stall cycles each.
        @(posedge CLK); #1;
        v2 = 1'b0; v3 = 1'b1;
        rd = 1'b0; wr = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40;
        wdata = 32'h0BADF00D; rda = 5'd0; mtr = 1'b0; rw = 1'b0;
        count_stall3(n);
        chk("l3_sw_stalls", 32'(n), 32'd4);
        chk("l3_sw_rw", 32'(rw3), 32'd0);
        @(posedge CLK); #1;
        rd = 1'b1; wr = 1'b0; rda = 5'd21; mtr = 1'b1; rw = 1'b1;
        count_stall3(n);
        chk("l3_lw_stalls", 32'(n), 32'd4);
        chk("l3_lw_data", data3, 32'h0BADF00D);
        chk("l3_lw_rw", 32'(rw3), 32'd1);
        chk("l3_lw_mtr", 32'(mtr3), 32'd1);
        chk("l3_lw_rd", 32'(rda3), 32'd21);
        @(posedge CLK); #1;
        v3 = 1'b0;
        @(negedge CLK);
        chk("l3_idle_data", data3, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
